// File: rtl/arith_pkg.sv
// arith_pkg: opcodes, status bit positions and FSM states shared by multicycle_arith_unit
// and its iterative multiply/divide core.
package arith_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SLT = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_ABS = 3'b100;
    localparam logic [2:0] OP_REM = 3'b101;

    localparam int ST_OVF  = 0;
    localparam int ST_ZERO = 1;
    localparam int ST_NEG  = 2;
    localparam int ST_ERR  = 3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// seq_muldiv_core: unsigned magnitude shift-add multiplier and restoring divider, one step per clock.
// The remainder output exists only when ARITH_REM_EN is defined.
module seq_muldiv_core #(
    parameter int M = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [M-1:0]   mag_a,
    input  logic [M-1:0]   mag_b,
    output logic           done,
    output logic [2*M-1:0] product,
    output logic [M-1:0]   quotient
`ifdef ARITH_REM_EN
    ,
    output logic [M-1:0]   remainder
`endif
);

    localparam int CW = $clog2(M + 1);

    logic [CW-1:0]  cnt_q;
    logic [2*M-1:0] acc_q, acc_d;
    logic [2*M-1:0] mcand_q, mcand_d;
    logic [M-1:0]   mplier_q, mplier_d;
    logic [M-1:0]   quo_q, quo_d;
    logic [M-1:0]   rem_q, rem_d;
    logic [M-1:0]   dvsr_q;
    logic [M:0]     shifted;

    // Both engines step together; the caller picks whichever result it asked for.
    always_comb begin
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        shifted  = {rem_q, quo_q[M-1]};
        if (shifted >= {1'b0, dvsr_q}) begin
            rem_d = shifted[M-1:0] - dvsr_q;
            quo_d = {quo_q[M-2:0], 1'b1};
        end else begin
            rem_d = shifted[M-1:0];
            quo_d = {quo_q[M-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
        end else if (start) begin
            cnt_q    <= CW'(M);
            acc_q    <= '0;
            mcand_q  <= {{M{1'b0}}, mag_b};
            mplier_q <= mag_a;
            quo_q    <= mag_a;
            rem_q    <= '0;
            dvsr_q   <= mag_b;
        end else if (cnt_q != '0) begin
            cnt_q    <= cnt_q - 1'b1;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
        end
    end

    // Outputs show the step being taken now, so the final values are ready on the last edge.
    assign done     = (cnt_q == CW'(1));
    assign product  = acc_d;
    assign quotient = quo_d;
`ifdef ARITH_REM_EN
    assign remainder = rem_d;
`endif

endmodule

// File: rtl/multicycle_arith_unit.sv
// multicycle_arith_unit: signed ALU with valid/ready handshake and iterative MUL/DIV.
// Define ARITH_REM_EN to enable opcode 101 (REM) from the divide engine.
module multicycle_arith_unit
    import arith_pkg::*;
#(
    parameter int N = 3,
    parameter int M = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_op,
    input  logic [M-1:0] i_arg_A,
    input  logic [M-1:0] i_arg_B,
    output logic         o_valid,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);

    state_t state_q, state_d;

    logic signed [M-1:0] a_s, b_s, sum, abs_a, abs_b;
    logic                accept, is_mul, is_div, is_multi;
    logic signed [M-1:0] sc_res;
    logic                sc_err, sc_ovf;

    logic                mul_q, neg_q, bz_q;
    logic                core_done;
    logic [2*M-1:0]      product;
    logic [M-1:0]        quotient;
    logic signed [2*M-1:0] prod_s;
    logic signed [M-1:0] quo_s, fin_res;
    logic                fin_err, fin_ovf;
`ifdef ARITH_REM_EN
    logic                is_rem, rem_q, sign_a_q;
    logic [M-1:0]        remainder;
`endif

    function automatic logic [3:0] make_status(input logic [M-1:0] res, input logic err,
                                               input logic ovf);
        logic [3:0] st;
        st          = '0;
        st[ST_ERR]  = err;
        st[ST_NEG]  = res[M-1];
        st[ST_ZERO] = (res == '0);
        st[ST_OVF]  = ovf;
        return st;
    endfunction

    assign a_s     = i_arg_A;
    assign b_s     = i_arg_B;
    assign o_ready = (state_q == IDLE) && !i_reset;
    assign o_valid = (state_q == DONE);
    assign accept  = i_valid && o_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid) state_d = is_multi ? BUSY : DONE;
            BUSY:    if (core_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode and single-cycle datapath, evaluated on the live inputs at the accept edge.
    always_comb begin
        is_mul   = (i_op == N'(OP_MUL));
        is_div   = (i_op == N'(OP_DIV));
`ifdef ARITH_REM_EN
        is_rem   = (i_op == N'(OP_REM));
        is_multi = is_mul || is_div || is_rem;
`else
        is_multi = is_mul || is_div;
`endif
        sum    = a_s + b_s;
        abs_a  = a_s[M-1] ? -a_s : a_s;
        abs_b  = b_s[M-1] ? -b_s : b_s;
        sc_res = '0;
        sc_err = 1'b0;
        sc_ovf = 1'b0;
        case (i_op)
            N'(OP_ADD): begin
                sc_res = sum;
                sc_ovf = (a_s[M-1] == b_s[M-1]) && (sum[M-1] != a_s[M-1]);
            end
            N'(OP_SLT): sc_res[0] = (a_s < b_s);
            N'(OP_ABS): begin
                sc_res = abs_a;
                sc_ovf = a_s[M-1] && abs_a[M-1];
            end
            N'(OP_MUL), N'(OP_DIV): sc_res = '0;
`ifdef ARITH_REM_EN
            N'(OP_REM): sc_res = '0;
`endif
            default: sc_err = 1'b1;
        endcase
    end

    seq_muldiv_core #(.M(M)) u_core (
        .clk      (i_clk),
        .rst      (i_reset),
        .start    (accept && is_multi),
        .mag_a    (abs_a),
        .mag_b    (abs_b),
        .done     (core_done),
        .product  (product),
`ifdef ARITH_REM_EN
        .remainder(remainder),
`endif
        .quotient (quotient)
    );

    // Sign fix-up of the magnitude results; a positive quotient with its MSB set is MIN / -1.
    always_comb begin
        prod_s  = neg_q ? -product : product;
        quo_s   = neg_q ? -quotient : quotient;
        fin_res = '0;
        fin_err = 1'b0;
        fin_ovf = 1'b0;
        if (mul_q) begin
            fin_res = prod_s[M-1:0];
            fin_ovf = (prod_s[2*M-1:M] != {M{prod_s[M-1]}});
        end
`ifdef ARITH_REM_EN
        else if (rem_q) begin
            if (bz_q) fin_err = 1'b1;
            else      fin_res = sign_a_q ? -remainder : remainder;
        end
`endif
        else if (bz_q) begin
            fin_err = 1'b1;
        end else begin
            fin_res = quo_s;
            fin_ovf = !neg_q && quotient[M-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_result <= '0;
            o_status <= '0;
            mul_q    <= 1'b0;
            neg_q    <= 1'b0;
            bz_q     <= 1'b0;
`ifdef ARITH_REM_EN
            rem_q    <= 1'b0;
            sign_a_q <= 1'b0;
`endif
        end else if (accept) begin
            if (is_multi) begin
                mul_q    <= is_mul;
                neg_q    <= a_s[M-1] ^ b_s[M-1];
                bz_q     <= (b_s == '0);
`ifdef ARITH_REM_EN
                rem_q    <= is_rem;
                sign_a_q <= a_s[M-1];
`endif
            end else begin
                o_result <= sc_res;
                o_status <= make_status(sc_res, sc_err, sc_ovf);
            end
        end else if ((state_q == BUSY) && core_done) begin
            o_result <= fin_res;
            o_status <= make_status(fin_res, fin_err, fin_ovf);
        end
    end

endmodule

// File: tb/tb_multicycle_arith_unit.sv
// tb_multicycle_arith_unit: directed vector table, multi-cycle corner sequences and
// randomized ops against an integer reference model, for N=3, M=4.
module tb_multicycle_arith_unit;

    localparam int N = 3;
    localparam int M = 4;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_op;
    logic [M-1:0] i_arg_A;
    logic [M-1:0] i_arg_B;
    logic         o_valid;
    logic [M-1:0] o_result;
    logic [3:0]   o_status;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic [3:0] st;
        bit         multi;
        string      name;
    } vec_t;

    vec_t tbl[$];

    multicycle_arith_unit #(.N(N), .M(M)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_arg_A (i_arg_A),
        .i_arg_B (i_arg_B),
        .o_valid (o_valid),
        .o_result(o_result),
        .o_status(o_status)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed integer arithmetic, then wrap to 4 bits.
    function automatic void model(input logic [2:0] op, input logic [3:0] a4, input logic [3:0] b4,
                                  output logic [3:0] res, output logic [3:0] st, output bit multi);
        int a, b, v;
        bit err, ovf;
        a = int'($signed(a4));
        b = int'($signed(b4));
        v = 0; err = 0; ovf = 0; multi = 0;
        case (op)
            3'd0: begin v = a + b; ovf = (v > 7) || (v < -8); end
            3'd1: v = (a < b) ? 1 : 0;
            3'd2: begin multi = 1; v = a * b; ovf = (v > 7) || (v < -8); end
            3'd3: begin
                multi = 1;
                if (b == 0) err = 1;
                else begin v = a / b; ovf = (v > 7); end
            end
            3'd4: begin v = (a < 0) ? -a : a; ovf = (v > 7); end
`ifdef ARITH_REM_EN
            3'd5: begin
                multi = 1;
                if (b == 0) err = 1;
                else v = a % b;
            end
`endif
            default: err = 1;
        endcase
        res = v[3:0];
        st  = {err, res[3], (res == 4'd0), ovf};
    endfunction

    task automatic add_vec(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] res, input logic [3:0] st, input bit multi,
                           input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.st = st; v.multi = multi; v.name = name;
        tbl.push_back(v);
    endtask

    // One transaction from IDLE: latency, result, status, ready during DONE, hold afterwards.
    task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] er, input logic [3:0] es, input bit multi,
                          input string name);
        int lat;
        @(negedge i_clk);
        check({name, "_ready_idle"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_op = op; i_arg_A = a; i_arg_B = b;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_op    = 3'($urandom);
        i_arg_A = 4'($urandom);
        i_arg_B = 4'($urandom);
        if (multi) check({name, "_ready_busy"}, 32'(o_ready), 32'd0);
        lat = 0;
        while (!o_valid && lat < 3 * M) begin
            @(posedge i_clk); #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), multi ? 32'(M) : 32'd0);
        check({name, "_result"}, 32'(o_result), 32'(er));
        check({name, "_status"}, 32'(o_status), 32'(es));
        check({name, "_ready_done"}, 32'(o_ready), 32'd0);
        @(posedge i_clk); #1;
        check({name, "_valid_drop"}, 32'(o_valid), 32'd0);
        check({name, "_result_hold"}, 32'(o_result), 32'(er));
    endtask

    initial begin
        int cnt, bad, seen;
        logic [2:0] rop;
        logic [3:0] ra, rb, rres, rst;
        bit rmulti;

        add_vec(3'd0, 4'h7, 4'h1, 4'b1000, 4'b0101, 0, "add_7_1");
        add_vec(3'd0, 4'hF, 4'h1, 4'b0000, 4'b0010, 0, "add_m1_1");
        add_vec(3'd1, 4'hC, 4'h3, 4'b0001, 4'b0000, 0, "slt_m4_3");
        add_vec(3'd1, 4'hD, 4'hD, 4'b0000, 4'b0010, 0, "slt_m3_m3");
        add_vec(3'd1, 4'h4, 4'hB, 4'b0000, 4'b0010, 0, "slt_4_m5");
        add_vec(3'd2, 4'h3, 4'hE, 4'b1010, 4'b0100, 1, "mul_3_m2");
        add_vec(3'd2, 4'h3, 4'h5, 4'b1111, 4'b0101, 1, "mul_3_5");
        add_vec(3'd3, 4'h7, 4'hE, 4'b1101, 4'b0100, 1, "div_7_m2");
        add_vec(3'd3, 4'h5, 4'h0, 4'b0000, 4'b1010, 1, "div_5_0");
        add_vec(3'd3, 4'h8, 4'hF, 4'b1000, 4'b0101, 1, "div_m8_m1");
`ifdef ARITH_REM_EN
        add_vec(3'd5, 4'h7, 4'hE, 4'b0001, 4'b0000, 1, "rem_7_m2");
`else
        add_vec(3'd5, 4'h7, 4'hE, 4'b0000, 4'b1010, 0, "rem_invalid");
`endif
        add_vec(3'd4, 4'h8, 4'h0, 4'b1000, 4'b0101, 0, "abs_m8");
        add_vec(3'd4, 4'hB, 4'h0, 4'b0101, 4'b0000, 0, "abs_m5");
        add_vec(3'd7, 4'h3, 4'h2, 4'b0000, 4'b1010, 0, "op_111");

        // Reset state
        i_reset = 1'b1; i_valid = 1'b0; i_op = '0; i_arg_A = '0; i_arg_B = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_result", 32'(o_result), 32'd0);
        check("rst_status", 32'(o_status), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        check("rst_release_ready", 32'(o_ready), 32'd1);

        foreach (tbl[i])
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].st, tbl[i].multi, tbl[i].name);

        // Reset during BUSY aborts the multiply
        run_op(3'd0, 4'h7, 4'h1, 4'b1000, 4'b0101, 0, "pre_abort_add");
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 3'd2; i_arg_A = 4'h3; i_arg_B = 4'hE;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #3;
        i_reset = 1'b1;
        #1;
        check("abort_ready", 32'(o_ready), 32'd0);
        check("abort_valid", 32'(o_valid), 32'd0);
        check("abort_result", 32'(o_result), 32'd0);
        check("abort_status", 32'(o_status), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge i_clk); #1;
            if (i == 0) check("abort_release_ready", 32'(o_ready), 32'd1);
            if (o_valid) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);

        // i_valid held high: accepted only from IDLE
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 3'd0; i_arg_A = 4'h1; i_arg_B = 4'h2;
        cnt = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk); #1;
            if (o_valid) begin
                cnt++;
                if (o_result !== 4'd3) bad++;
            end
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        check("held_add_count", 32'(cnt), 32'd5);
        check("held_add_bad", 32'(bad), 32'd0);

        @(negedge i_clk);
        i_valid = 1'b1; i_op = 3'd2; i_arg_A = 4'h3; i_arg_B = 4'h5;
        cnt = 0; bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge i_clk); #1;
            if (o_valid) begin
                cnt++;
                if (o_result !== 4'b1111 || o_status !== 4'b0101) bad++;
            end
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        check("held_mul_count", 32'(cnt), 32'd2);
        check("held_mul_bad", 32'(bad), 32'd0);

        // Randomized ops against the model
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            model(rop, ra, rb, rres, rst, rmulti);
            run_op(rop, ra, rb, rres, rst, rmulti, $sformatf("rnd%0d_op%0d", i, rop));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_arith_unit.md
Name: multicycle_arith_unit

Overview:
- Parametrised successor to the fixed-width synchronous arithmetic unit.
- Signed two's-complement ALU with generic data width M and opcode width N.
- Adds a valid/ready handshake and an iterative multiply/divide engine.
- Single-cycle ops complete in one clock; MUL/DIV take M iteration cycles. Sits between operand source and writeback, one op in flight.

Parameters:
- N, 3, opcode width (minimum 3)
- M, 8, data width in bits (minimum 2)

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  request strobe
- o_ready  out  1  unit can accept a request
- i_op  in  N  opcode
- i_arg_A  in  M  operand A, signed
- i_arg_B  in  M  operand B, signed
- o_valid  out  1  one-cycle result strobe
- o_result  out  M  result
- o_status  out  4  {error, negative, zero, overflow} as bits [3:0]

Behaviour:
- Reset is asynchronous and active-high, and uses one clock, i_clk.
- While i_reset is high: state=IDLE, o_ready=0, o_valid=0, o_result=0, o_status=0, all internal registers cleared. o_ready rises in the first cycle after deassertion.
- Reset mid-operation aborts the op; no o_valid is ever produced for it.
- FSM states:
  - IDLE: o_ready=1.
  - BUSY: o_ready=0; iteration counter runs M..1.
  - DONE: o_ready=0, o_valid=1 for exactly one cycle, then back to IDLE.
- Accept at edge k when i_valid && o_ready. Operands and op are latched at that edge; later input changes are ignored. i_valid outside IDLE is ignored (not queued).
- Single-cycle ops: result and status are registered at edge k; DONE (o_valid) is in the cycle after edge k.
- MUL/DIV: BUSY for edges k+1..k+M. The result is written and DONE entered at edge k+M.
- Throughput is 1 op per 2 cycles for single-cycle ops.
- o_result and o_status hold their last value after o_valid drops.
- Opcodes:
  - 000 ADD: A+B, wraps modulo 2^M; overflow=signed overflow.
  - 001 SLT: result=1 if A<B signed, else 0; overflow=0.
  - 010 MUL: computes |A|*|B| by shift-add into a 2M-bit accumulator, negated if signs differ; result = low M bits. Overflow=1 if the 2M-bit product is not the sign-extension of the low M bits.
  - 011 DIV: restoring division on magnitudes; quotient truncates toward zero; sign = signA^signB.
    - B=0: result=0, error=1, overflow=0, still M cycles.
    - A=-2^(M-1), B=-1: result=-2^(M-1), overflow=1.
  - 100 ABS: |A|. For A=-2^(M-1): result=-2^(M-1), overflow=1.
  - 101 REM: see Optional Feature.
  - 110, 111 (and 101 without feature): invalid. result=0, error=1, single-cycle.
- Status flags:
  - zero = (result==0).
  - negative = result[M-1].
  - error = invalid op or divide by zero.

Optional Feature:
- Macro ARITH_REM_EN.
- Defined: opcode 101 REM returns the signed remainder from the DIV engine. Sign follows A; same latency as DIV. B=0 gives result=0, error=1.
- Undefined: 101 is an invalid opcode; the remainder register is not retained.

Decomposition:
- Package arith_pkg holds:
  - op code localparams (OP_ADD, OP_SLT, OP_MUL, OP_DIV, OP_ABS, OP_REM)
  - status bit indices (ST_OVF=0, ST_ZERO=1, ST_NEG=2, ST_ERR=3)
  - FSM state enum (IDLE, BUSY, DONE)
- Sub-module seq_muldiv_core, parametrised by M:
  - magnitude shift-add / restoring-divide datapath with counter, start/done
  - outputs 2M-bit product, quotient, remainder
- Top holds the FSM, single-cycle ops, sign fix-up and flags.

Test Plan (N=3, M=4):
- MUL 3*-2 accepted, i_reset pulsed at cycle 2 of BUSY → o_valid never asserts, o_result=0000, o_status=0000, o_ready=1 cycle after release.
- ADD 7+1 → o_valid one cycle after accept, o_result=1000, o_status=0101; ADD -1+1 → 0000, status 0010; o_ready=0 during the DONE cycle.
- SLT -4,3 → 0001 status 0000; SLT -3,-3 → 0000 status 0010; SLT 4,-5 → 0000 status 0010.
- MUL 3*-2 → o_valid exactly after edge k+4, result 1010, status 0100. MUL 3*5 → 1111, status 0101. Arguments changed during BUSY do not affect the result.
- DIV 7/-2 → 1101 status 0100; DIV 5/0 → 0000 status 1010 after 4 cycles; DIV -8/-1 → 1000 status 0101. With ARITH_REM_EN: REM 7,-2 → 0001 status 0000; without it → 0000 status 1010.
- ABS -8 → 1000 status 0101; ABS -5 → 0101 status 0000. Op 111 → 0000 status 1010. i_valid held high across all ops → each op accepted only in IDLE, no duplicates.
